// File: rtl/cypher_pkg.sv
// rtl/cypher_pkg.sv - shared state encoding and sizing helper for the cypher detector
package cypher_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_SUCCESS = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKED  = 3'd5
    } cypher_state_e;

    // Never returns less than 1 so that a degenerate range still yields a usable vector.
    function automatic int cypher_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cypher_down_counter.sv
// rtl/cypher_down_counter.sv - loadable down counter with zero and terminal-count flags
module cypher_down_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    // Lets the owner leave its wait state on the same edge the count reaches zero.
    assign last = (count == W'(1));

endmodule

// File: rtl/cypher_detector_param.sv
// rtl/cypher_detector_param.sv - parametrised cypher detector with lockout; CYPHER_TIMEOUT_EN adds inter-digit timeout
module cypher_detector_param
    import cypher_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int SUM_W          = 8,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [DIGITS*DIGIT_W-1:0]             cypher,
    input  logic [DIGIT_W-1:0]                    nextInput,
    input  logic                                  read,
    output logic                                  res,
    output logic                                  fail,
    output logic                                  locked,
    output logic [SUM_W-1:0]                      sum,
    output logic [cypher_clog2(DIGITS+1)-1:0]     digitIndex,
    output logic [cypher_clog2(MAX_TRIES+1)-1:0]  tries,
    output logic [STATE_W-1:0]                    states
);

    localparam int IDX_W  = cypher_clog2(DIGITS + 1);
    localparam int TRY_W  = cypher_clog2(MAX_TRIES + 1);
    localparam int LOCK_W = cypher_clog2(LOCKOUT_CYCLES + 1);

    localparam logic [STATE_W-1:0] S_IDLE    = ST_IDLE;
    localparam logic [STATE_W-1:0] S_COLLECT = ST_COLLECT;
    localparam logic [STATE_W-1:0] S_CHECK   = ST_CHECK;
    localparam logic [STATE_W-1:0] S_SUCCESS = ST_SUCCESS;
    localparam logic [STATE_W-1:0] S_FAIL    = ST_FAIL;
    localparam logic [STATE_W-1:0] S_LOCKED  = ST_LOCKED;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               match;
    logic               accept;
    logic               digit_eq;
    logic [DIGIT_W-1:0] exp_digit;
    logic               lock_load;
    logic               lock_dec;
    logic               lock_zero;
    logic               lock_last;
    logic               timeout_hit;

    assign states = state;
    assign accept = read && ((state == S_IDLE) || (state == S_COLLECT));

    // digitIndex is 0 in IDLE, so the same select serves the first digit.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitIndex == IDX_W'(i)) begin
                exp_digit = cypher[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_eq = (nextInput == exp_digit);

    assign lock_load = (state == S_FAIL) && (next_state == S_LOCKED);
    assign lock_dec  = (state == S_LOCKED);

    cypher_down_counter #(
        .W (LOCK_W)
    ) u_lock_counter (
        .clock      (clock),
        .resetn     (reset),
        .load       (lock_load),
        .load_value (LOCK_W'(LOCKOUT_CYCLES)),
        .dec        (lock_dec),
        .zero       (lock_zero),
        .last       (lock_last)
    );

`ifdef CYPHER_TIMEOUT_EN
    localparam int IDLE_W = cypher_clog2(TIMEOUT_CYCLES + 1);

    logic idle_dec;
    logic idle_zero;
    logic idle_last;

    assign idle_dec = (state == S_COLLECT) && !read;

    cypher_down_counter #(
        .W (IDLE_W)
    ) u_idle_counter (
        .clock      (clock),
        .resetn     (reset),
        .load       (accept),
        .load_value (IDLE_W'(TIMEOUT_CYCLES)),
        .dec        (idle_dec),
        .zero       (idle_zero),
        .last       (idle_last)
    );

    assign timeout_hit = idle_dec && (idle_last || idle_zero);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (read) next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (read) begin
                    if (digitIndex == LAST_IDX) next_state = S_CHECK;
                end else if (timeout_hit) begin
                    next_state = S_FAIL;
                end
            end
            S_CHECK:   next_state = match ? S_SUCCESS : S_FAIL;
            S_SUCCESS: next_state = S_IDLE;
            S_FAIL:    next_state = (tries == TRY_MAX) ? S_LOCKED : S_IDLE;
            S_LOCKED: begin
                if (lock_last || lock_zero) next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            res        <= 1'b0;
            fail       <= 1'b0;
            locked     <= 1'b0;
            sum        <= '0;
            digitIndex <= '0;
            tries      <= '0;
            match      <= 1'b0;
        end else begin
            state  <= next_state;
            res    <= (next_state == S_SUCCESS);
            fail   <= (next_state == S_FAIL);
            locked <= (next_state == S_LOCKED);

            // The match flag is accumulated without early exit so timing never leaks the bad position.
            if (accept) begin
                if (state == S_IDLE) begin
                    sum        <= SUM_W'(nextInput);
                    digitIndex <= IDX_W'(1);
                    match      <= digit_eq;
                end else begin
                    sum        <= sum + SUM_W'(nextInput);
                    digitIndex <= digitIndex + IDX_W'(1);
                    match      <= match & digit_eq;
                end
            end

            if (next_state == S_FAIL) begin
                tries      <= tries + TRY_W'(1);
                digitIndex <= '0;
            end
            if (next_state == S_SUCCESS) begin
                tries      <= '0;
                digitIndex <= '0;
            end
            if ((state == S_LOCKED) && (next_state == S_IDLE)) begin
                tries <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cypher_detector_param.sv
// tb/tb_cypher_detector_param.sv - randomized and directed checks of cypher_detector_param against a queue-based model
module tb_cypher_detector_param;

    localparam int DIGITS         = 4;
    localparam int DIGIT_W        = 4;
    localparam int SUM_W          = 8;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int TIMEOUT_CYCLES = 32;
`ifdef CYPHER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cypher = 16'h1234;
    logic [3:0]  nextInput = 4'h0;
    logic        read = 1'b0;

    logic        res, fail, locked;
    logic [7:0]  sum;
    logic [2:0]  digitIndex;
    logic [1:0]  tries;
    logic [2:0]  states;

    logic        unused_res4, unused_fail4, unused_locked4;
    logic [3:0]  sum4;
    logic [2:0]  unused_idx4;
    logic [1:0]  unused_tries4;
    logic [2:0]  unused_states4;

    cypher_detector_param #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .SUM_W(SUM_W), .MAX_TRIES(MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .cypher(cypher), .nextInput(nextInput), .read(read),
        .res(res), .fail(fail), .locked(locked), .sum(sum), .digitIndex(digitIndex),
        .tries(tries), .states(states)
    );

    cypher_detector_param #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .SUM_W(4), .MAX_TRIES(MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut4 (
        .clock(clock), .reset(reset), .cypher(cypher), .nextInput(nextInput), .read(read),
        .res(unused_res4), .fail(unused_fail4), .locked(unused_locked4), .sum(sum4),
        .digitIndex(unused_idx4), .tries(unused_tries4), .states(unused_states4)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Model: the attempt is a queue of digits; sum, index and verdict are derived from it.
    int q[$];
    int m_state     = 0;
    int m_tries     = 0;
    int m_lock_left = 0;
    int m_idle      = 0;

    function automatic int cy_digit(input int i);
        return int'((cypher >> ((DIGITS - 1 - i) * DIGIT_W))) & ((1 << DIGIT_W) - 1);
    endfunction

    function automatic bit attempt_ok();
        for (int i = 0; i < DIGITS; i++)
            if (q[i] != cy_digit(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int q_sum(input int w);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s % (1 << w);
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_state = 0; m_tries = 0; m_lock_left = 0; m_idle = 0;
            q.delete();
        end else begin
            case (m_state)
                0: if (read) begin
                    q.delete(); q.push_back(int'(nextInput)); m_idle = 0; m_state = 1;
                end
                1: if (read) begin
                    q.push_back(int'(nextInput)); m_idle = 0;
                    if (q.size() == DIGITS) m_state = 2;
                end else if (TO_EN) begin
                    m_idle++;
                    if (m_idle == TIMEOUT_CYCLES) begin m_tries++; m_state = 4; end
                end
                2: if (attempt_ok()) begin m_tries = 0; m_state = 3; end
                   else begin m_tries++; m_state = 4; end
                3: m_state = 0;
                4: if (m_tries == MAX_TRIES) begin m_state = 5; m_lock_left = LOCKOUT_CYCLES; end
                   else m_state = 0;
                5: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin m_tries = 0; m_state = 0; end
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("states", int'(states), m_state);
            check("res", int'(res), int'(m_state == 3));
            check("fail", int'(fail), int'(m_state == 4));
            check("locked", int'(locked), int'(m_state == 5));
            check("tries", int'(tries), m_tries);
            check("sum", int'(sum), q_sum(SUM_W));
            check("sum4", int'(sum4), q_sum(4));
            check("digitIndex", int'(digitIndex), (m_state == 1 || m_state == 2) ? q.size() : 0);
        end
    end

    task automatic cyc(input bit r, input int d);
        read = r;
        nextInput = DIGIT_W'(d);
        @(posedge clock);
        #1;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        cyc(1'b1, a); cyc(1'b1, b); cyc(1'b1, c); cyc(1'b1, d);
    endtask

    initial begin
        int lock_cnt;
        int d;
        bit r;

        reset = 1'b0;
        cyc(1'b0, 0); cyc(1'b0, 0);
        cmp_en = 1'b1;
        check("rst_states", int'(states), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_idx", int'(digitIndex), 0);
        check("rst_tries", int'(tries), 0);
        reset = 1'b1;

        enter(1, 2, 3, 4);
        check("ok_check_state", int'(states), 2);
        cyc(1'b0, 0);
        check("ok_res", int'(res), 1);
        check("ok_sum", int'(sum), 8'h0A);
        check("ok_tries", int'(tries), 0);
        cyc(1'b0, 0);

        enter(1, 2, 3, 5);
        cyc(1'b0, 0);
        check("bad_fail", int'(fail), 1);
        check("bad_tries", int'(tries), 1);
        check("bad_sum", int'(sum), 8'h0B);
        cyc(1'b0, 0);
        check("bad_idle", int'(states), 0);

        enter(1, 1, 1, 1); cyc(1'b0, 0); cyc(1'b0, 0);
        enter(9, 9, 9, 9); cyc(1'b0, 0);
        check("lock_tries", int'(tries), 3);
        cyc(1'b0, 0);
        check("lock_rise", int'(locked), 1);
        lock_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, int'($urandom_range(0, 15)));
            if (locked) lock_cnt++;
            else break;
        end
        check("lock_len", lock_cnt, LOCKOUT_CYCLES);
        check("lock_clear_tries", int'(tries), 0);
        enter(1, 2, 3, 4); cyc(1'b0, 0);
        check("post_lock_res", int'(res), 1);
        cyc(1'b0, 0);

        enter(15, 15, 15, 15);
        check("wrap_sum4", int'(sum4), 4'hC);
        check("wrap_sum8", int'(sum), 8'h3C);
        cyc(1'b0, 0); cyc(1'b0, 0);

        cyc(1'b1, 1); cyc(1'b1, 2);
        reset = 1'b0;
        cyc(1'b0, 0);
        check("mid_rst_state", int'(states), 0);
        check("mid_rst_idx", int'(digitIndex), 0);
        check("mid_rst_tries", int'(tries), 0);
        reset = 1'b1;
        enter(1, 2, 3, 4); cyc(1'b0, 0);
        check("mid_rst_res", int'(res), 1);
        cyc(1'b0, 0);

        for (int k = 0; k < 3; k++) begin
            enter(0, 0, 0, 0); cyc(1'b0, 0); cyc(1'b0, 0);
        end
        check("lock2_rise", int'(locked), 1);
        cyc(1'b0, 0); cyc(1'b0, 0);
        reset = 1'b0;
        cyc(1'b0, 0);
        check("lock_rst_locked", int'(locked), 0);
        check("lock_rst_tries", int'(tries), 0);
        reset = 1'b1;
        enter(1, 2, 3, 4); cyc(1'b0, 0);
        check("lock_rst_res", int'(res), 1);
        cyc(1'b0, 0);

        cyc(1'b1, 1); cyc(1'b1, 2);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) cyc(1'b0, 0);
`ifdef CYPHER_TIMEOUT_EN
        check("to_fail", int'(fail), 1);
        check("to_tries", int'(tries), 1);
        cyc(1'b0, 0);
`else
        check("to_wait_state", int'(states), 1);
        check("to_wait_idx", int'(digitIndex), 2);
        cyc(1'b1, 3); cyc(1'b1, 4); cyc(1'b0, 0);
        check("to_late_res", int'(res), 1);
        cyc(1'b0, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 60);
            if ((m_state == 0 || m_state == 1) && $urandom_range(0, 99) < 75)
                d = cy_digit((m_state == 0) ? 0 : q.size());
            else
                d = int'($urandom_range(0, 15));
            if (m_state == 0 && !r && $urandom_range(0, 19) == 0)
                cypher = 16'($urandom);
            reset = ($urandom_range(0, 149) != 0);
            cyc(r, d);
        end
        reset = 1'b1;
        cyc(1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
